pll_reset_sequencer: RTL

Sequences the reset and lock of the board clock PLL (50 MHz reference in; 25.2 MHz video and 18 MHz auxiliary clocks out), running entirely in the reference-clock domain. It pulses the PLL reset and waits for a stable lock. It then releases a system reset for downstream logic. On loss of lock, timeout or an explicit request, it re-runs the sequence and counts retries for debug.

---
 rtl/pll_reset_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer for the board clock PLL, running entirely in the reference clock domain.
// Pulses the PLL reset, waits for a stable lock, then releases the downstream system reset.
module pll_reset_sequencer #(
    parameter int RESET_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int RELOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOSS_FILTER_CYCLES    = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [1:0] dbg_state
);

    localparam int MAX_AB     = (RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RESET_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CD     = (RELOCK_TIMEOUT_CYCLES > LOSS_FILTER_CYCLES) ? RELOCK_TIMEOUT_CYCLES : LOSS_FILTER_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABILIZE = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic [7:0]       retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             retry_bump;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_bump  = 1'b0;
        lock_meta_d = pll_locked;
        lock_s_d    = lock_meta_q;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = S_RESET_PLL;
                    retry_bump = 1'b1;
                end
            end
            S_STABILIZE: begin
                if (!lock_s_q) state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // In RUN the counter is the loss filter: it only advances on low lock samples.
                if (lock_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    state_d    = S_RESET_PLL;
                    retry_bump = 1'b1;
                end
                if (force_relock) state_d = S_RESET_PLL;
            end
            default: state_d = S_RESET_PLL;
        endcase

        if (state_d != state_q) cnt_d = '0;

        retry_d = (retry_bump && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;

        // Outputs decode the next state so they move on the same edge as the state.
        pll_rst_d   = (state_d == S_RESET_PLL);
        sys_reset_d = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            retry_q     <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;
    assign dbg_state   = state_q;

endmodule
